// File: rtl/hamming_encoder_stream.sv
// ---------------------------------------------------------------------------
// hamming_encoder_stream
//
// Streaming SECDED (8,4) Hamming encoder with an output FIFO and a one-shot
// error-injection port. Produces codewords in the bit layout the matching
// Hamming decoder consumes:
//   out_code[0]=P1 [1]=P2 [2]=D1 [3]=P3 [4]=D2 [5]=D3 [6]=D4 [7]=P4
// with in_data[0]=D1 .. in_data[3]=D4, even parity throughout.
//
// Ports
//   clk          rising-edge clock
//   rst          synchronous, active-high reset
//   in_data      4-bit data word
//   in_valid     in_data is valid
//   in_ready     encoder can accept a word (registered FIFO-not-full flag)
//   out_code     FIFO head codeword, driven from a register
//   out_valid    FIFO not empty (registered)
//   out_ready    downstream accepts out_code
//   inj_arm      single-cycle pulse that arms error injection
//   inj_mask     XOR mask, sampled when inj_arm=1
//   inj_pending  injection armed but not yet applied
//   word_cnt     number of emitted codewords, wraps at all-ones
// ---------------------------------------------------------------------------
module hamming_encoder_stream #(
    parameter int DEPTH = 2,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [3:0]       in_data,
    input  logic             in_valid,
    output logic             in_ready,
    output logic [7:0]       out_code,
    output logic             out_valid,
    input  logic             out_ready,
    input  logic             inj_arm,
    input  logic [7:0]       inj_mask,
    output logic             inj_pending,
    output logic [CNT_W-1:0] word_cnt
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_CNT = (AW + 1)'(DEPTH);

    // Storage and control state
    logic [7:0]       mem_q [DEPTH];
    logic [7:0]       mem_d [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic             in_ready_q, in_ready_d;
    logic             out_valid_q, out_valid_d;
    logic [7:0]       out_code_q, out_code_d;
    logic             inj_pending_q, inj_pending_d;
    logic [7:0]       mask_q, mask_d;
    logic [CNT_W-1:0] word_cnt_q, word_cnt_d;

    // Encoder datapath
    logic       d1, d2, d3, d4;
    logic       p1, p2, p3, p4;
    logic [6:0] code_lo;
    logic [7:0] code_raw;
    logic [7:0] apply_mask;
    logic [7:0] code_w;
    logic       push;
    logic       pop;

    always_comb begin
        d1 = in_data[0];
        d2 = in_data[1];
        d3 = in_data[2];
        d4 = in_data[3];
        p1 = d1 ^ d2 ^ d4;
        p2 = d1 ^ d3 ^ d4;
        p3 = d2 ^ d3 ^ d4;
        code_lo  = {d4, d3, d2, p3, d1, p2, p1};
        // Overall parity bit makes the full 8-bit word even.
        p4       = ^code_lo;
        code_raw = {p4, code_lo};
    end

    always_comb begin
        push = in_valid & in_ready_q;
        pop  = out_valid_q & out_ready;

        // A same-cycle arm applies its own mask directly; otherwise a pending
        // stored mask is consumed by this accept.
        apply_mask = 8'h00;
        if (inj_arm) begin
            apply_mask = inj_mask;
        end else if (inj_pending_q) begin
            apply_mask = mask_q;
        end
        code_w = code_raw ^ apply_mask;
    end

    always_comb begin
        mem_d = mem_q;
        if (push) begin
            mem_d[wr_ptr_q] = code_w;
        end

        wr_ptr_d = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + (AW + 1)'(1);
        end else if (!push && pop) begin
            count_d = count_q - (AW + 1)'(1);
        end

        in_ready_d  = (count_d != FULL_CNT);
        out_valid_d = (count_d != '0);

        // Next head: if the slot the read pointer lands on is the one being
        // written this edge, forward the new codeword; otherwise read storage.
        // When the FIFO goes empty the last value is held.
        out_code_d = out_code_q;
        if (count_d != '0) begin
            if (push && (wr_ptr_q == rd_ptr_d)) begin
                out_code_d = code_w;
            end else begin
                out_code_d = mem_q[rd_ptr_d];
            end
        end
    end

    always_comb begin
        inj_pending_d = inj_pending_q;
        mask_d        = mask_q;
        if (push) begin
            // Whatever mask applied is spent on this word.
            inj_pending_d = 1'b0;
            mask_d        = 8'h00;
        end else if (inj_arm) begin
            // Re-arming while pending simply replaces the mask.
            inj_pending_d = 1'b1;
            mask_d        = inj_mask;
        end

        word_cnt_d = pop ? word_cnt_q + CNT_W'(1) : word_cnt_q;
    end

    // FIFO storage carries no reset; occupancy and pointers define validity.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            count_q       <= '0;
            in_ready_q    <= 1'b1;
            out_valid_q   <= 1'b0;
            out_code_q    <= 8'h00;
            inj_pending_q <= 1'b0;
            mask_q        <= 8'h00;
            word_cnt_q    <= '0;
        end else begin
            wr_ptr_q      <= wr_ptr_d;
            rd_ptr_q      <= rd_ptr_d;
            count_q       <= count_d;
            in_ready_q    <= in_ready_d;
            out_valid_q   <= out_valid_d;
            out_code_q    <= out_code_d;
            inj_pending_q <= inj_pending_d;
            mask_q        <= mask_d;
            word_cnt_q    <= word_cnt_d;
        end
    end

    assign in_ready    = in_ready_q;
    assign out_valid   = out_valid_q;
    assign out_code    = out_code_q;
    assign inj_pending = inj_pending_q;
    assign word_cnt    = word_cnt_q;

endmodule

// File: tb/tb_hamming_encoder_stream.sv
// ---------------------------------------------------------------------------
// tb_hamming_encoder_stream
//
// Directed bench for hamming_encoder_stream (DEPTH=2, CNT_W=4). Inputs are
// driven on the falling edge, outputs sampled on the following falling edge.
// Expected codewords come from a hand-computed table indexed by data value
// (D1 = in_data[0]).
// ---------------------------------------------------------------------------
module tb_hamming_encoder_stream;

    logic       clk = 1'b0;
    logic       rst;
    logic [3:0] in_data;
    logic       in_valid;
    logic       in_ready;
    logic [7:0] out_code;
    logic       out_valid;
    logic       out_ready;
    logic       inj_arm;
    logic [7:0] inj_mask;
    logic       inj_pending;
    logic [3:0] word_cnt;

    int n_cmp = 0;
    int n_err = 0;

    // Hand-computed codewords for data 0x0 .. 0xF.
    logic [7:0] enc_tbl [16] = '{
        8'h00, 8'h87, 8'h99, 8'h1E, 8'hAA, 8'h2D, 8'h33, 8'hB4,
        8'h4B, 8'hCC, 8'hD2, 8'h55, 8'hE1, 8'h66, 8'h78, 8'hFF
    };
    logic [3:0] seq4 [4] = '{4'h0, 4'h1, 4'hD, 4'hF};

    hamming_encoder_stream #(.DEPTH(2), .CNT_W(4)) dut (
        .clk         (clk),
        .rst         (rst),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .out_code    (out_code),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .inj_arm     (inj_arm),
        .inj_mask    (inj_mask),
        .inj_pending (inj_pending),
        .word_cnt    (word_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        rst       = 1'b1;
        in_data   = 4'h0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        inj_arm   = 1'b0;
        inj_mask  = 8'h00;
        do_reset();

        // Reset state
        chk("rst_in_ready",  32'(in_ready),    32'd1);
        chk("rst_out_valid", 32'(out_valid),   32'd0);
        chk("rst_out_code",  32'(out_code),    32'h00);
        chk("rst_pending",   32'(inj_pending), 32'd0);
        chk("rst_word_cnt",  32'(word_cnt),    32'd0);

        // Short stream, one word per cycle, each visible one cycle after accept
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = seq4[0];
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("seq4_code",  32'(out_code),  32'(enc_tbl[seq4[i]]));
            chk("seq4_valid", 32'(out_valid), 32'd1);
            if (i < 3) in_data = seq4[i + 1];
            else       in_valid = 1'b0;
        end

        // All 16 values, with even total parity
        in_valid = 1'b1;
        in_data  = 4'h0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            chk("all16_code",   32'(out_code), 32'(enc_tbl[i]));
            chk("all16_parity", 32'(^out_code), 32'd0);
            chk("all16_ready",  32'(in_ready), 32'd1);
            if (i < 15) in_data = 4'(i + 1);
            else        in_valid = 1'b0;
        end
        @(negedge clk);
        chk("drain_valid", 32'(out_valid), 32'd0);
        chk("drain_hold",  32'(out_code),  32'hFF);

        // Backpressure with DEPTH=2
        do_reset();
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h1;
        @(negedge clk);
        chk("bp_code1",  32'(out_code), 32'h87);
        chk("bp_ready1", 32'(in_ready), 32'd1);
        in_data = 4'h2;
        @(negedge clk);
        chk("bp_full_ready", 32'(in_ready), 32'd0);
        chk("bp_full_code",  32'(out_code), 32'h87);
        in_data = 4'h3;
        @(negedge clk);
        chk("bp_hold_ready", 32'(in_ready), 32'd0);
        chk("bp_hold_code",  32'(out_code), 32'h87);
        out_ready = 1'b1;
        @(negedge clk);
        chk("bp_pop1_code",  32'(out_code), 32'h99);
        chk("bp_pop1_ready", 32'(in_ready), 32'd1);
        chk("bp_pop1_cnt",   32'(word_cnt), 32'd1);
        @(negedge clk);
        in_valid = 1'b0;
        chk("bp_pop2_code",  32'(out_code),  32'h1E);
        chk("bp_pop2_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("bp_empty_valid", 32'(out_valid), 32'd0);
        chk("bp_empty_code",  32'(out_code),  32'h1E);
        chk("bp_cnt",         32'(word_cnt),  32'd3);

        // Single-bit injection: 0xD -> 8'h66 ^ 8'h04
        do_reset();
        out_ready = 1'b1;
        inj_arm   = 1'b1;
        inj_mask  = 8'h04;
        @(negedge clk);
        inj_arm  = 1'b0;
        inj_mask = 8'h00;
        chk("inj1_pending_set", 32'(inj_pending), 32'd1);
        in_valid = 1'b1;
        in_data  = 4'hD;
        @(negedge clk);
        chk("inj1_code",       32'(out_code),    32'h62);
        chk("inj1_pending_clr", 32'(inj_pending), 32'd0);
        @(negedge clk);
        chk("inj1_next_clean", 32'(out_code), 32'h66);

        // Double-bit injection in the same cycle as the accept
        inj_arm  = 1'b1;
        inj_mask = 8'h81;
        in_data  = 4'h0;
        @(negedge clk);
        inj_arm  = 1'b0;
        inj_mask = 8'h00;
        in_valid = 1'b0;
        chk("inj2_code",    32'(out_code),    32'h81);
        chk("inj2_pending", 32'(inj_pending), 32'd0);

        // Re-arm replaces the mask; only one word is corrupted
        inj_arm  = 1'b1;
        inj_mask = 8'h01;
        @(negedge clk);
        inj_mask = 8'h80;
        @(negedge clk);
        inj_arm  = 1'b0;
        inj_mask = 8'h00;
        in_valid = 1'b1;
        in_data  = 4'h0;
        @(negedge clk);
        chk("inj3_code", 32'(out_code), 32'h80);
        @(negedge clk);
        chk("inj3_clean", 32'(out_code), 32'h00);

        // Zero mask corrupts nothing but still consumes the arm
        in_valid = 1'b0;
        inj_arm  = 1'b1;
        inj_mask = 8'h00;
        @(negedge clk);
        inj_arm = 1'b0;
        chk("inj0_pending", 32'(inj_pending), 32'd1);
        in_valid = 1'b1;
        in_data  = 4'hF;
        @(negedge clk);
        in_valid = 1'b0;
        chk("inj0_code",    32'(out_code),    32'hFF);
        chk("inj0_pending_clr", 32'(inj_pending), 32'd0);

        // Counter wrap with CNT_W=4: 17 back-to-back words
        do_reset();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'h5;
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            if (c == 17) in_valid = 1'b0;
            if (c == 16) chk("wrap_15", 32'(word_cnt), 32'd15);
            if (c == 17) chk("wrap_0",  32'(word_cnt), 32'd0);
            if (c == 18) chk("wrap_1",  32'(word_cnt), 32'd1);
        end

        // Mid-stream reset: fill FIFO, arm injection, then reset with a word in flight
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = 4'h1;
        @(negedge clk);
        in_data = 4'h2;
        @(negedge clk);
        in_valid = 1'b0;
        inj_arm  = 1'b1;
        inj_mask = 8'hFF;
        @(negedge clk);
        inj_arm  = 1'b0;
        inj_mask = 8'h00;
        chk("mr_pre_full",    32'(in_ready),    32'd0);
        chk("mr_pre_pending", 32'(inj_pending), 32'd1);
        rst      = 1'b1;
        in_valid = 1'b1;
        in_data  = 4'h3;
        @(negedge clk);
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("mr_out_valid", 32'(out_valid),   32'd0);
        chk("mr_in_ready",  32'(in_ready),    32'd1);
        chk("mr_pending",   32'(inj_pending), 32'd0);
        chk("mr_word_cnt",  32'(word_cnt),    32'd0);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = 4'h1;
        @(negedge clk);
        in_valid = 1'b0;
        chk("mr_clean_code",  32'(out_code),  32'h87);
        chk("mr_clean_valid", 32'(out_valid), 32'd1);
        @(negedge clk);
        chk("mr_cnt_after", 32'(word_cnt), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
